seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised successor to the single-digit hex-to-7-segment decoder.
- Time-multiplexes DIGITS hex digits onto one shared segment bus with per-digit enables.
- Adds a refresh prescaler, tear-free frame-synchronous value update, leading-zero blanking, decimal points and selectable output polarity.
- Sits between datapath/debug registers and the board's common-anode/cathode display.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- CLK_DIV, 50000, clock cycles each digit is enabled (>=2).
- ACTIVE_LOW, 1, 1 = seg/dp/an driven active-low; 0 = active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- value  in  4*DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 least significant
- dp_in  in  DIGITS  decimal-point request per digit
- load  in  1  one-cycle strobe; captures value and dp_in
- blank_lz  in  1  1 = blank leading zero digits
- seg  out  7  segments {g,f,e,d,c,b,a}; bit0 = a
- dp  out  1  decimal point of the enabled digit
- an  out  DIGITS  digit enables; one-hot when active
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0
- update_pending  out  1  a captured value is waiting for the frame boundary

Behaviour:
- Reset (async):
  - prescaler=0, idx=0, display and pending registers = 0, pend_valid=0.
  - All outputs registered and inactive: an, seg and dp off (all 1s if ACTIVE_LOW); frame_done=0.
- Prescaler:
  - Counts 0..CLK_DIV-1. tick = (count==CLK_DIV-1), then count wraps to 0.
  - On tick, idx increments and wraps from DIGITS-1 to 0.
  - The wrap is the frame boundary: frame_done=1 for the following cycle.
- Output latency: outputs are registered from the current idx with 1 cycle of latency. After reset deasserts, the first edge drives digit 0.
- Decode table, active-high, hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Inverted when ACTIVE_LOW.
- Load handling:
  - load copies value and dp_in into pending and sets pend_valid.
  - On a frame boundary with pend_valid=1, display <= pending and pend_valid <= 0.
  - load in the same cycle as a boundary writes display directly and leaves pend_valid=0.
  - Multiple loads within one frame: the last one wins.
- update_pending = pend_valid.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked when it and all digits above it are 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps an active and outputs seg all off; dp still follows dp_in.
  - blank_lz is sampled live, not latched.
- Reset mid-frame: all state is cleared immediately and outputs blank asynchronously; pending data is lost.

Test Plan:
- DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1, reset pulse -> during reset an=1111, seg=7F, dp=1. After release: an=1110, then 1101 4 cycles later, then 1011, 0111. frame_done pulses once per 16 cycles.
- load value=16'h1A3F, dp_in=0100 mid-frame -> update_pending=1 until the wrap. Next frame shows digits 0..3 = F,3,A,1 (seg=0E,30,08,79). dp=0 only while an=1011.
- blank_lz=1, loaded value=16'h0007 -> digits 3,2,1 seg=7F, digit 0 seg=78. Same test with value=16'h0000: digit 0 seg=40.
- load asserted exactly in the boundary cycle with value=16'h2222 -> update_pending stays 0; new frame shows 2 on all digits (seg=24).
- Two loads (16'h1111, then 16'h5555) in one frame -> next frame shows only 5 (seg=12).
- Assert rst midway through the scan of digit 2 -> outputs blank in the same cycle (no clock edge). After release: idx=0, display=0, pend_valid=0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bundle between a register/datapath source and the multiplexed 7-segment scan driver.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_lz;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;
    logic                update_pending;

    modport master (
        output value, dp_in, load, blank_lz,
        input  seg, dp, an, frame_done, update_pending
    );

    modport slave (
        input  value, dp_in, load, blank_lz,
        output seg, dp, an, frame_done, update_pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: scans DIGITS digits over one shared segment bus.
// New values are staged and swapped in only at the frame boundary so a frame never tears.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] disp_val;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   disp_dp;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_valid;
    logic                tick;
    logic                wrap;
    logic                lz_run;
    logic [DIGITS-1:0]   lz_blank;
    logic [DIGITS-1:0]   an_onehot;
    logic [3:0]          cur_digit;
    logic [6:0]          seg_on;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // A load landing on the boundary goes straight to the display; otherwise it is staged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_val   <= '0;
            disp_dp    <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (bus.load && wrap) begin
            disp_val   <= bus.value;
            disp_dp    <= bus.dp_in;
            pend_valid <= 1'b0;
        end else if (bus.load) begin
            pend_val   <= bus.value;
            pend_dp    <= bus.dp_in;
            pend_valid <= 1'b1;
        end else if (wrap && pend_valid) begin
            disp_val   <= pend_val;
            disp_dp    <= pend_dp;
            pend_valid <= 1'b0;
        end
    end

    always_comb begin
        lz_blank  = '0;
        an_onehot = '0;
        lz_run    = bus.blank_lz;
        // Walk down from the top digit; digit 0 is never considered.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run && (disp_val[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_run;
        end
        an_onehot[idx] = 1'b1;
        cur_digit      = disp_val[{idx, 2'b00} +: 4];
        seg_on         = lz_blank[idx] ? 7'h00 : hex_decode(cur_digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.seg        <= {7{ACTIVE_LOW}};
            bus.dp         <= ACTIVE_LOW;
            bus.an         <= {DIGITS{ACTIVE_LOW}};
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg        <= seg_on ^ {7{ACTIVE_LOW}};
            bus.dp         <= disp_dp[idx] ^ ACTIVE_LOW;
            bus.an         <= an_onehot ^ {DIGITS{ACTIVE_LOW}};
            bus.frame_done <= wrap;
        end
    end

    assign bus.update_pending = pend_valid;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-arithmetic model compared every cycle plus pinned literals.
module tb_seg7_scan_driver;
    localparam int D = 4;
    localparam int C = 4;
    localparam int F = D * C;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad   = 0;

    seg7_scan_driver_if #(.DIGITS(D)) bus();

    seg7_scan_driver #(.DIGITS(D), .CLK_DIV(C), .ACTIVE_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: n counts clock edges since reset release; the digit shown after edge n
    // is ((n-1)/C) mod D and edge n is a frame boundary when n is a multiple of F.
    int          mn;
    int          md;
    bit          live = 1'b0;
    logic [15:0] shown_v, pend_v, tmp;
    logic [3:0]  shown_dp, pend_dp;
    bit          pv;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_up;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            live = 1'b1;
            mn = 0; shown_v = '0; shown_dp = '0; pend_v = '0; pend_dp = '0; pv = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_up = 1'b0;
        end else begin
            mn++;
            md    = ((mn - 1) / C) % D;
            e_an  = ~(4'(1) << md);
            tmp   = shown_v >> (4 * md);
            e_seg = (bus.blank_lz && md != 0 && tmp == 16'h0) ? 7'h7F : ~hex_tab[tmp[3:0]];
            e_dp  = !shown_dp[md];
            e_fd  = (mn % F == 0);
            if (bus.load) begin
                if (mn % F == 0) begin
                    shown_v = bus.value; shown_dp = bus.dp_in; pv = 1'b0;
                end else begin
                    pend_v = bus.value; pend_dp = bus.dp_in; pv = 1'b1;
                end
            end else if (mn % F == 0 && pv) begin
                shown_v = pend_v; shown_dp = pend_dp; pv = 1'b0;
            end
            e_up = pv;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("cyc_an", 32'(bus.an), 32'(e_an));
            chk("cyc_seg", 32'(bus.seg), 32'(e_seg));
            chk("cyc_dp", 32'(bus.dp), 32'(e_dp));
            chk("cyc_frame_done", 32'(bus.frame_done), 32'(e_fd));
            chk("cyc_update_pending", 32'(bus.update_pending), 32'(e_up));
        end
    end

    task automatic wait_n(input int target);
        int guard = 0;
        while (mn != target && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (mn != target) chk("wait_timeout", 32'(mn), 32'(target));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
        bus.value = v; bus.dp_in = dpv; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        bus.value = '0; bus.dp_in = '0; bus.load = 1'b0; bus.blank_lz = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        wait_n(1);  chk("scan_an0", 32'(bus.an), 32'hE);
        wait_n(5);  chk("scan_an1", 32'(bus.an), 32'hD);
        wait_n(9);  chk("scan_an2", 32'(bus.an), 32'hB);
        wait_n(13); chk("scan_an3", 32'(bus.an), 32'h7);
        wait_n(16); chk("fd_high", 32'(bus.frame_done), 32'h1);
        wait_n(17); chk("fd_low", 32'(bus.frame_done), 32'h0);

        wait_n(18); do_load(16'h1A3F, 4'b0100);
        chk("pend_set", 32'(bus.update_pending), 32'h1);
        wait_n(31); chk("pend_hold", 32'(bus.update_pending), 32'h1);
        wait_n(32); chk("pend_clear", 32'(bus.update_pending), 32'h0);
        wait_n(33); chk("d0_F", 32'(bus.seg), 32'h0E);
        wait_n(37); chk("d1_3", 32'(bus.seg), 32'h30);
        wait_n(41); chk("d2_A", 32'(bus.seg), 32'h08); chk("d2_dp", 32'(bus.dp), 32'h0);
        wait_n(45); chk("d3_1", 32'(bus.seg), 32'h79); chk("d3_dp", 32'(bus.dp), 32'h1);

        wait_n(50); bus.blank_lz = 1'b1; do_load(16'h0007, 4'b0000);
        wait_n(65); chk("lz_d0_7", 32'(bus.seg), 32'h78);
        wait_n(69); chk("lz_d1", 32'(bus.seg), 32'h7F); chk("lz_d1_an", 32'(bus.an), 32'hD);
        wait_n(73); chk("lz_d2", 32'(bus.seg), 32'h7F);
        wait_n(77); chk("lz_d3", 32'(bus.seg), 32'h7F);
        wait_n(82); do_load(16'h0000, 4'b0000);
        wait_n(97);  chk("lz_zero_d0", 32'(bus.seg), 32'h40);
        wait_n(101); chk("lz_zero_d1", 32'(bus.seg), 32'h7F);
        bus.blank_lz = 1'b0;

        wait_n(111); do_load(16'h2222, 4'b0000);
        chk("bnd_no_pend", 32'(bus.update_pending), 32'h0);
        wait_n(113); chk("bnd_d0", 32'(bus.seg), 32'h24);
        wait_n(114); do_load(16'h1111, 4'b0000);
        chk("multi_pend", 32'(bus.update_pending), 32'h1);
        wait_n(117); chk("bnd_d1", 32'(bus.seg), 32'h24);
        wait_n(118); do_load(16'h5555, 4'b0000);
        wait_n(129); chk("last_d0", 32'(bus.seg), 32'h12);
        wait_n(133); chk("last_d1", 32'(bus.seg), 32'h12);
        wait_n(141); chk("last_d3", 32'(bus.seg), 32'h12);

        wait_n(150); do_load(16'h9999, 4'b1111);
        wait_n(154); chk("pre_rst_an", 32'(bus.an), 32'hB);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_an", 32'(bus.an), 32'hF);
        chk("mid_rst_seg", 32'(bus.seg), 32'h7F);
        chk("mid_rst_dp", 32'(bus.dp), 32'h1);
        chk("mid_rst_up", 32'(bus.update_pending), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_n(1);  chk("post_rst_an", 32'(bus.an), 32'hE); chk("post_rst_seg", 32'(bus.seg), 32'h40);
        wait_n(17); chk("pend_lost", 32'(bus.seg), 32'h40);
        wait_n(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
